// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared command codes, FSM states and target select for the boot loader
// Contents:
//   CMD_IM / CMD_RB / CMD_END : header byte codes
//   state_t                   : loader FSM states
//   target_t                  : write-port select (instruction memory or register bank)
package mips_boot_pkg;

    localparam logic [7:0] CMD_IM  = 8'h01;
    localparam logic [7:0] CMD_RB  = 8'h02;
    localparam logic [7:0] CMD_END = 8'hFF;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_CNT,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic {
        TGT_IM,
        TGT_RB
    } target_t;

endpackage

// File: rtl/mips_boot_loader_if.sv
// rtl/mips_boot_loader_if.sv - byte stream, IM/RB write ports and status of the boot loader
// Signals:
//   in_valid/in_data/in_ready     : byte stream handshake (transfer when valid && ready)
//   im_we/im_addr/im_wdata        : instruction memory write port
//   rb_we/rb_addr/rb_wdata        : register bank write port
//   cpu_run/load_err/words_loaded : status towards the CPU
// Modports: master = loader side, slave = stream source / memory side.
interface mips_boot_loader_if #(
    parameter int DATA_W   = 32,
    parameter int BYTE_W   = 8,
    parameter int IM_DEPTH = 64,
    parameter int RB_DEPTH = 32
);
    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int RB_AW = $clog2(RB_DEPTH);

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              im_we;
    logic [IM_AW-1:0]  im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              rb_we;
    logic [RB_AW-1:0]  rb_addr;
    logic [DATA_W-1:0] rb_wdata;
    logic              cpu_run;
    logic              load_err;
    logic [15:0]       words_loaded;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output im_we, im_addr, im_wdata,
        output rb_we, rb_addr, rb_wdata,
        output cpu_run, load_err, words_loaded
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  im_we, im_addr, im_wdata,
        input  rb_we, rb_addr, rb_wdata,
        input  cpu_run, load_err, words_loaded
    );

endinterface

// File: rtl/mips_boot_loader_word_assembler.sv
// rtl/mips_boot_loader_word_assembler.sv - serial-in byte to big-endian word assembler
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : a data byte is accepted this cycle
//   byte_in    : accepted byte
//   word_done  : this byte completes a word (combinational)
//   word       : completed word, valid while word_done is high
module boot_word_assembler #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_done,
    output logic [DATA_W-1:0] word
);
    localparam int BPW = DATA_W / BYTE_W;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] byte_cnt;

    assign word_done = shift_en && (byte_cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            byte_cnt <= word_done ? '0 : byte_cnt + CW'(1);
        end
    end

    // Only the leading bytes are stored; the final byte is spliced in
    // combinationally so the word is available in the cycle it arrives.
    generate
        if (BPW > 1) begin : g_multi
            logic [DATA_W-BYTE_W-1:0] shreg;

            assign word = {shreg, byte_in};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shreg <= '0;
                end else if (shift_en) begin
                    shreg <= word[DATA_W-BYTE_W-1:0];
                end
            end
        end else begin : g_single
            assign word = byte_in;
        end
    endgenerate

endmodule

// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - stream-driven loader for instruction memory and register bank
// Ports:
//   clk_CPU   : system clock, rising edge
//   rst_CPU_n : asynchronous active-low reset
//   bus       : mips_boot_loader_if.master (stream in, IM/RB write ports, status)
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BYTE_W   = 8,
    parameter int IM_DEPTH = 64,
    parameter int RB_DEPTH = 32
) (
    input  logic                 clk_CPU,
    input  logic                 rst_CPU_n,
    mips_boot_loader_if.master   bus
);
    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int RB_AW = $clog2(RB_DEPTH);

    state_t            state;
    state_t            state_nx;
    target_t           target;
    logic [BYTE_W-1:0] cur_addr;
    logic [BYTE_W-1:0] remaining;
    logic              accept;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic [31:0]       span;
    logic [31:0]       depth;

    assign bus.in_ready = (state == ST_HDR) || (state == ST_ADDR) ||
                          (state == ST_CNT) || (state == ST_DATA);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.cpu_run  = (state == ST_DONE);
    assign bus.load_err = (state == ST_ERR);

    // Range check for the CNT byte: first word address plus count must fit.
    assign span  = 32'(cur_addr) + 32'(bus.in_data);
    assign depth = (target == TGT_IM) ? 32'(IM_DEPTH) : 32'(RB_DEPTH);

    boot_word_assembler #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_asm (
        .clk       (clk_CPU),
        .rst_n     (rst_CPU_n),
        .shift_en  (accept && (state == ST_DATA)),
        .byte_in   (bus.in_data),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            state <= ST_HDR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_HDR: begin
                if (accept) begin
                    if (bus.in_data == BYTE_W'(CMD_IM) || bus.in_data == BYTE_W'(CMD_RB)) begin
                        state_nx = ST_ADDR;
                    end else if (bus.in_data == BYTE_W'(CMD_END)) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_ERR;
                    end
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    state_nx = ST_CNT;
                end
            end
            ST_CNT: begin
                if (accept) begin
                    if (bus.in_data == '0) begin
                        state_nx = ST_HDR;
                    end else if (span > depth) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leaving on the last byte lets the next header arrive during the strobe cycle.
                if (word_done && remaining == BYTE_W'(1)) begin
                    state_nx = ST_HDR;
                end
            end
            ST_DONE: state_nx = ST_DONE;
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_HDR;
        endcase
    end

    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            target           <= TGT_IM;
            cur_addr         <= '0;
            remaining        <= '0;
            bus.im_we        <= 1'b0;
            bus.im_addr      <= '0;
            bus.im_wdata     <= '0;
            bus.rb_we        <= 1'b0;
            bus.rb_addr      <= '0;
            bus.rb_wdata     <= '0;
            bus.words_loaded <= '0;
        end else begin
            bus.im_we <= 1'b0;
            bus.rb_we <= 1'b0;
            if (accept && state == ST_HDR) begin
                target <= (bus.in_data == BYTE_W'(CMD_RB)) ? TGT_RB : TGT_IM;
            end
            if (accept && state == ST_ADDR) begin
                cur_addr <= bus.in_data;
            end
            if (accept && state == ST_CNT) begin
                remaining <= bus.in_data;
            end
            if (word_done) begin
                if (target == TGT_IM) begin
                    bus.im_we    <= 1'b1;
                    bus.im_addr  <= cur_addr[IM_AW-1:0];
                    bus.im_wdata <= word;
                end else begin
                    bus.rb_we    <= 1'b1;
                    bus.rb_addr  <= cur_addr[RB_AW-1:0];
                    bus.rb_wdata <= word;
                end
                cur_addr  <= cur_addr + BYTE_W'(1);
                remaining <= remaining - BYTE_W'(1);
                if (bus.words_loaded != 16'hFFFF) begin
                    bus.words_loaded <= bus.words_loaded + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// tb/tb_mips_boot_loader.sv - self-checking bench for mips_boot_loader
module tb_mips_boot_loader;

    logic clk_CPU = 1'b0;
    logic rst_CPU_n = 1'b0;
    always #5 clk_CPU = ~clk_CPU;

    mips_boot_loader_if bus ();

    mips_boot_loader dut (
        .clk_CPU   (clk_CPU),
        .rst_CPU_n (rst_CPU_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: parse the whole stream up front ----------------
    logic [7:0]  stim[$];
    int          m_kind[256];     // 0 none, 1 IM write, 2 RB write, keyed by index of the word's last byte
    logic [31:0] m_addr[256];
    logic [31:0] m_data[256];
    int          m_stop;          // index of the byte that ends loading (END or fault), -1 if none
    int          m_outcome;       // 0 still loading, 1 done, 2 error
    int          m_nwords;

    function automatic void build_model();
        int i, n, h, a, c, dep, last;
        for (int k = 0; k < 256; k++) m_kind[k] = 0;
        m_stop = -1; m_outcome = 0; m_nwords = 0;
        i = 0; n = stim.size();
        while (i < n) begin
            h = stim[i];
            if (h == 8'hFF) begin m_stop = i; m_outcome = 1; break; end
            if (h != 1 && h != 2) begin m_stop = i; m_outcome = 2; break; end
            if (i + 2 >= n) break;
            a = stim[i+1];
            c = stim[i+2];
            dep = (h == 1) ? 64 : 32;
            if (c != 0 && a + c > dep) begin m_stop = i + 2; m_outcome = 2; break; end
            for (int w = 0; w < c; w++) begin
                last = i + 3 + 4*w + 3;
                if (last >= n) break;
                m_kind[last] = h;
                m_addr[last] = a + w;
                m_data[last] = {stim[last-3], stim[last-2], stim[last-1], stim[last]};
                m_nwords++;
            end
            i = i + 3 + 4*c;
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 0;
    bit          pend;
    int          pend_idx, nacc, exp_wl, kk;
    bit          term;
    int          log_kind[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk_CPU) begin
        if (chk_en) begin
            kk = 0;
            if (pend) begin
                kk = m_kind[pend_idx];
                if (pend_idx == m_stop) term = 1;
            end
            if (kk != 0 && exp_wl < 65535) exp_wl++;
            chk("im_we", bus.im_we, kk == 1);
            chk("rb_we", bus.rb_we, kk == 2);
            if (kk == 1) begin
                chk("im_addr", bus.im_addr, m_addr[pend_idx]);
                chk("im_wdata", bus.im_wdata, m_data[pend_idx]);
            end
            if (kk == 2) begin
                chk("rb_addr", bus.rb_addr, m_addr[pend_idx]);
                chk("rb_wdata", bus.rb_wdata, m_data[pend_idx]);
            end
            chk("in_ready", bus.in_ready, !term);
            chk("cpu_run", bus.cpu_run, term && m_outcome == 1);
            chk("load_err", bus.load_err, term && m_outcome == 2);
            chk("words_loaded", bus.words_loaded, exp_wl);
            if (bus.im_we) begin log_kind.push_back(1); log_addr.push_back(bus.im_addr); log_data.push_back(bus.im_wdata); end
            if (bus.rb_we) begin log_kind.push_back(2); log_addr.push_back(bus.rb_addr); log_data.push_back(bus.rb_wdata); end
            pend = bus.in_valid && bus.in_ready;
            if (pend) begin pend_idx = nacc; nacc++; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        while ($urandom_range(99) < gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk_CPU); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_CPU);
            if (bus.in_ready) begin
                @(posedge clk_CPU); #1;
                ok = 1;
                break;
            end
            @(posedge clk_CPU); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk_CPU); #3;
        rst_CPU_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_rst_im_we"}, bus.im_we, 0);
        chk({tag, "_rst_rb_we"}, bus.rb_we, 0);
        chk({tag, "_rst_cpu_run"}, bus.cpu_run, 0);
        chk({tag, "_rst_load_err"}, bus.load_err, 0);
        chk({tag, "_rst_words_loaded"}, bus.words_loaded, 0);
        chk({tag, "_rst_im_wdata"}, bus.im_wdata, 0);
        repeat (2) @(posedge clk_CPU);
        @(negedge clk_CPU);
        rst_CPU_n = 1'b1;
        @(posedge clk_CPU); #1;
    endtask

    task automatic run(input string tag, input int gap, input bit rst_first);
        bit ok;
        chk_en = 0;
        if (rst_first) do_reset(tag);
        build_model();
        pend = 0; nacc = 0; exp_wl = 0; term = 0;
        log_kind.delete(); log_addr.delete(); log_data.delete();
        chk_en = 1;
        for (int k = 0; k < stim.size(); k++) begin
            send_byte(stim[k], gap, ok);
            if (!ok) begin
                if (m_stop < 0 || k <= m_stop) chk({tag, "_accept"}, ok, 1);
                break;
            end
        end
        repeat (3) @(posedge clk_CPU);
        #1;
        chk_en = 0;
        chk({tag, "_nwords"}, log_kind.size(), m_nwords);
    endtask

    int          s_kind[$];
    logic [31:0] s_addr[$];
    logic [31:0] s_data[$];
    int          tg, dep, cnt, ad;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        chk("init_im_we", bus.im_we, 0);
        chk("init_cpu_run", bus.cpu_run, 0);
        chk("init_words_loaded", bus.words_loaded, 0);
        @(negedge clk_CPU);
        rst_CPU_n = 1'b1;
        @(posedge clk_CPU); #1;

        // Partial word (2 of 4 data bytes), then reset mid-DATA.
        stim = {8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB};
        run("partial", 0, 0);
        do_reset("partial");
        chk("partial_cpu_run", bus.cpu_run, 0);
        chk("partial_words_loaded", bus.words_loaded, 0);

        // Resume from HDR without another reset: two IM words, END, and a byte that must be refused.
        stim = {8'h01, 8'h00, 8'h02, 8'h01, 8'h2A, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h0C, 8'hFF, 8'h01};
        run("im2", 0, 0);
        chk("im2_model_pin", m_data[6], 32'h012A0020);
        chk("im2_logsize", log_kind.size(), 2);
        if (log_kind.size() >= 2) begin
            chk("im2_w0_kind", log_kind[0], 1);
            chk("im2_w0_addr", log_addr[0], 0);
            chk("im2_w0_data", log_data[0], 32'h012A0020);
            chk("im2_w1_addr", log_addr[1], 1);
            chk("im2_w1_data", log_data[1], 32'h0000000C);
        end
        chk("im2_cpu_run", bus.cpu_run, 1);
        chk("im2_words_loaded", bus.words_loaded, 2);
        chk("im2_in_ready", bus.in_ready, 0);

        // Single RB word at the last index.
        stim = {8'h02, 8'h1F, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
        run("rb1", 0, 1);
        chk("rb1_logsize", log_kind.size(), 1);
        if (log_kind.size() >= 1) begin
            chk("rb1_kind", log_kind[0], 2);
            chk("rb1_addr", log_addr[0], 31);
            chk("rb1_data", log_data[0], 32'hDEADBEEF);
        end

        // RB range overflow: 31 + 2 > 32.
        stim = {8'h02, 8'h1F, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        run("rbovf", 0, 1);
        chk("rbovf_load_err", bus.load_err, 1);
        chk("rbovf_in_ready", bus.in_ready, 0);
        chk("rbovf_words", bus.words_loaded, 0);

        // IM exact fit: 62 + 2 == 64.
        stim = {8'h01, 8'h3E, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hFF};
        run("imfit", 20, 1);
        chk("imfit_words", bus.words_loaded, 2);
        chk("imfit_load_err", bus.load_err, 0);

        // Unknown header.
        stim = {8'h05, 8'h01};
        run("badhdr", 0, 1);
        chk("badhdr_load_err", bus.load_err, 1);
        chk("badhdr_cpu_run", bus.cpu_run, 0);

        // Zero count, then END.
        stim = {8'h01, 8'h05, 8'h00, 8'hFF};
        run("cnt0", 0, 1);
        chk("cnt0_cpu_run", bus.cpu_run, 1);
        chk("cnt0_words", bus.words_loaded, 0);

        // 3-word IM load, gap-free then with ~50% valid gaps.
        stim.delete();
        stim.push_back(8'h01);
        stim.push_back(8'($urandom_range(0, 61)));
        stim.push_back(8'h03);
        repeat (12) stim.push_back(8'($urandom));
        stim.push_back(8'hFF);
        run("gap0", 0, 1);
        s_kind = log_kind; s_addr = log_addr; s_data = log_data;
        run("gap50", 50, 1);
        chk("gap_logsize", log_kind.size(), 3);
        chk("gap_same_size", log_kind.size(), s_kind.size());
        for (int i = 0; i < 3; i++) begin
            if (i < log_kind.size() && i < s_kind.size()) begin
                chk("gap_same_addr", log_addr[i], s_addr[i]);
                chk("gap_same_data", log_data[i], s_data[i]);
            end
        end

        // Random multi-command streams with random gaps.
        for (int r = 0; r < 4; r++) begin
            stim.delete();
            for (int c = 0; c < 3; c++) begin
                tg  = $urandom_range(1, 2);
                dep = (tg == 1) ? 64 : 32;
                cnt = $urandom_range(0, 3);
                ad  = $urandom_range(0, dep - cnt);
                stim.push_back(8'(tg));
                stim.push_back(8'(ad));
                stim.push_back(8'(cnt));
                repeat (4*cnt) stim.push_back(8'($urandom));
            end
            stim.push_back(8'hFF);
            run("rand", 30, 1);
            chk("rand_cpu_run", bus.cpu_run, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Replaces simulation-only memory preloading of the instruction memory and register bank with a synthesizable loader.
- Accepts a byte stream over a valid/ready handshake and decodes load commands.
- Writes assembled big-endian words into the instruction memory (IM) or register bank (RB) write ports.
- Holds the CPU in stall until an END command arrives, then releases it by asserting cpu_run.

Parameters:
DATA_W, 32, word width written to IM/RB; must be a multiple of BYTE_W
BYTE_W, 8, stream symbol width
IM_DEPTH, 64, instruction memory words; IM_AW = clog2(IM_DEPTH)
RB_DEPTH, 32, register bank entries; RB_AW = clog2(RB_DEPTH)

Ports:
clk_CPU  in  1  system clock, rising edge
rst_CPU_n  in  1  asynchronous active-low reset
in_valid  in  1  stream byte valid
in_data  in  BYTE_W  stream byte
in_ready  out  1  loader accepts byte; transfer occurs when in_valid && in_ready at a rising edge
im_we  out  1  IM write strobe, one cycle per word
im_addr  out  IM_AW  IM word address
im_wdata  out  DATA_W  IM write data
rb_we  out  1  RB write strobe, one cycle per word
rb_addr  out  RB_AW  RB index
rb_wdata  out  DATA_W  RB write data
cpu_run  out  1  CPU enable; low while loading
load_err  out  1  sticky protocol error
words_loaded  out  16  total words written since reset, saturating at 0xFFFF

Behaviour:
- Reset, asynchronous on rst_CPU_n low, regardless of state: all outputs 0, FSM to HDR, byte counter 0. Any in-flight word is discarded and no write strobe is issued.
- Command format: HDR byte, then ADDR byte (start word address), then CNT byte (word count, 1..255), then CNT*(DATA_W/BYTE_W) data bytes, MSB first.
- HDR codes: 0x01 selects IM, 0x02 selects RB, 0xFF means END. Any other code goes to ERR.
- FSM states: HDR, ADDR, CNT, DATA, DONE, ERR.
- HDR: on 0x01/0x02, latch the target and go to ADDR. On 0xFF, go to DONE.
- ADDR: latch cur_addr and go to CNT.
- CNT:
  - If CNT==0, return to HDR with no writes.
  - If ADDR+CNT > target depth, go to ERR.
  - Otherwise latch remaining=CNT and go to DATA.
- DATA: shift each accepted byte into the word register.
- Word completion, on the final byte of a word:
  - The next cycle, the selected strobe (im_we or rb_we) is high for exactly one cycle, with addr=cur_addr and wdata=the assembled word.
  - cur_addr increments, remaining decrements, and words_loaded increments.
  - When remaining reaches 0, return to HDR in the same cycle as the strobe.
- in_ready is 1 in HDR/ADDR/CNT/DATA, including the strobe cycle. Back-to-back bytes therefore sustain full rate, with no bubble between words.
- in_ready is 0 in DONE and ERR.
- in_valid low stalls any state indefinitely with no timeout. Partial word assembly is preserved across stalls.
- DONE: cpu_run=1 from the cycle after the END byte is accepted, held until reset. Further stream bytes are never accepted.
- ERR: load_err=1 and cpu_run=0, held until reset. No writes are issued.
- im_we and rb_we are never high simultaneously. Address/data outputs hold their last values when strobes are low.

Decomposition:
- Shared package mips_boot_pkg holds:
  - command codes: CMD_IM=8'h01, CMD_RB=8'h02, CMD_END=8'hFF
  - FSM state enum
  - target enum {TGT_IM, TGT_RB}
- Sub-module boot_word_assembler, parametrised by DATA_W/BYTE_W:
  - serial-in shift register plus byte counter
  - outputs word_done and word

Test Plan:
- Reset mid-DATA after 2 of 4 bytes, then resume from HDR -> no strobe fires, cpu_run=0, words_loaded=0.
- Stream 01 00 02 | 01 2A 00 20 | 00 00 00 0C, then FF, with in_valid held high -> im_we pulses at addr 0 data 0x012A0020, then at addr 1 data 0x0000000C on the cycle after each 4th byte. cpu_run=1 one cycle after FF. words_loaded=2.
- Stream 02 1F 01 DE AD BE EF -> rb_we once, rb_addr=31, rb_wdata=0xDEADBEEF.
- Stream 02 1F 02 (addr 31 + count 2 > 32) -> load_err=1, no write, in_ready=0 persistently.
- Stream header 0x05 -> ERR. Separately, stream 01 05 00 then FF -> no write, cpu_run=1.
- Random in_valid gaps (about 50% duty) on a 3-word IM load -> identical writes to the gap-free case, with one strobe per word.
